// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider (MIPS DIV/DIVU).
package div_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, select.
module div_step
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;
   logic           fits;

   always_comb begin
      // The extra top bit keeps the shifted-out remainder MSB so the trial never wraps.
      rem_sh   = {rem, quo[WIDTH-1]};
      diff     = rem_sh - {1'b0, divisor};
      fits     = (rem_sh >= {1'b0, divisor});
      rem_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], fits};
   end

endmodule

// File: rtl/div.sv
// Iterative restoring divider: WIDTH CALC cycles plus one sign-fix cycle; quotient to LO, remainder to HI.
module div
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   input  logic             is_signed,
   input  logic             cancel,
   output logic [WIDTH-1:0] div_hi,
   output logic [WIDTH-1:0] div_lo,
   output logic             div_by_zero,
   output logic             ready
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   div_state_t       state;
   logic [CW-1:0]    counter;
   logic [WIDTH-1:0] rem, quo, abs_b_q;
   logic             a_sign, b_sign, sgn_q, b_zero;

   logic [WIDTH-1:0] abs_a, abs_b, rem_n, quo_n;
   logic             a_neg, b_neg;

   always_comb begin
      a_neg = is_signed && a[WIDTH-1];
      b_neg = is_signed && b[WIDTH-1];
      abs_a = a_neg ? -a : a;
      abs_b = b_neg ? -b : b;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (abs_b_q),
      .rem_next (rem_n),
      .quo_next (quo_n)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= DIV_IDLE;
         ready       <= 1'b1;
         counter     <= '0;
         rem         <= '0;
         quo         <= '0;
         abs_b_q     <= '0;
         a_sign      <= 1'b0;
         b_sign      <= 1'b0;
         sgn_q       <= 1'b0;
         b_zero      <= 1'b0;
         div_hi      <= '0;
         div_lo      <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            DIV_IDLE: begin
               // A simultaneous cancel drops the start.
               if (start && !cancel) begin
                  rem     <= '0;
                  quo     <= abs_a;
                  abs_b_q <= abs_b;
                  a_sign  <= a[WIDTH-1];
                  b_sign  <= b[WIDTH-1];
                  sgn_q   <= is_signed;
                  b_zero  <= (b == '0);
                  counter <= CW'(WIDTH);
                  state   <= DIV_CALC;
                  ready   <= 1'b0;
               end
            end
            DIV_CALC: begin
               if (cancel) begin
                  state <= DIV_IDLE;
                  ready <= 1'b1;
               end else begin
                  rem     <= rem_n;
                  quo     <= quo_n;
                  counter <= counter - CW'(1);
                  if (counter == CW'(1)) state <= DIV_FIX;
               end
            end
            DIV_FIX: begin
               if (!cancel) begin
                  div_lo      <= (sgn_q && (a_sign ^ b_sign)) ? -quo : quo;
                  div_hi      <= (sgn_q && a_sign) ? -rem : rem;
                  div_by_zero <= b_zero;
               end
               state <= DIV_IDLE;
               ready <= 1'b1;
            end
            default: begin
               state <= DIV_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative restoring divider: the inverse counterpart of the team's sequential multiplier, serving MIPS DIV/DIVU.
- Sits beside the multiplier in the execute stage and shares its start/ready handshake style.
- Writes the quotient to LO and the remainder to HI.
- Operands are latched at start, so the issuing stage may change the a/b buses freely while the divide is running.

Parameters:
- WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- a  input  WIDTH  dividend, sampled only on an accepted start
- b  input  WIDTH  divisor, sampled only on an accepted start
- start  input  1  request; accepted when start=1 and ready=1 at a clock edge
- is_signed  input  1  1=DIV, 0=DIVU; sampled with a/b
- cancel  input  1  flush (exception/branch); aborts an operation in flight
- div_hi  output  WIDTH  remainder of the last completed operation
- div_lo  output  WIDTH  quotient of the last completed operation
- div_by_zero  output  1  set if the last completed operation had b==0
- ready  output  1  high in IDLE; low while busy

Behaviour:
- Reset (resetn=0, async): state=IDLE, ready=1, div_hi=0, div_lo=0, div_by_zero=0, counter=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at an edge latches abs_a, abs_b, the sign flags and is_signed.
  - Loads the working remainder to 0, the working quotient to abs_a, and counter=WIDTH.
  - Goes to CALC.
  - start while not ready is ignored; there is no queuing.
- abs_x = (is_signed && x[WIDTH-1]) ? -x : x, taken as an unsigned WIDTH-bit value.
  - -2^31 therefore becomes 0x80000000 unsigned.
- CALC, one edge per quotient bit:
  - Shift {rem,quo} left by 1.
  - Compute a trial subtraction rem - abs_b at WIDTH+1 bits.
  - If non-negative: rem = difference and quo[0]=1; else quo[0]=0.
  - counter decrements; on the edge where counter goes 1->0, go to FIX.
- FIX, one edge:
  - Quotient sign: negate when is_signed && (a_sign ^ b_sign).
  - Remainder sign: negate when is_signed && a_sign, i.e. it follows the dividend.
  - Register div_lo, div_hi and div_by_zero; go to IDLE.
- Latency:
  - Accepting edge = edge 0.
  - Edges 1..WIDTH are CALC; edge WIDTH+1 is FIX.
  - ready and the new results are visible after edge WIDTH+1 (33 for WIDTH=32).
  - Back-to-back: a new start may be accepted on the edge right after ready rises.
- Outputs change only at the FIX edge; during CALC they hold the previous result.
- Divide by zero (b==0):
  - Same latency, no early exit.
  - The algorithm naturally yields quotient all-ones and remainder = abs_a, then applies the sign fix.
  - div_by_zero=1; the values are architecturally undefined, but the bench checks the values above.
- Overflow -2^31 / -1 (signed): quotient 0x80000000, remainder 0, no flag.
- Cancel:
  - cancel=1 at an edge in CALC or FIX returns to IDLE with ready=1.
  - div_hi, div_lo and div_by_zero are unchanged.
  - cancel in IDLE has no effect.
  - cancel and start together in IDLE: cancel wins, the start is dropped.
- resetn low mid-operation: immediate return to the reset values above.

Decomposition:
- Shared package (cpu defines) holds:
  - state encodings DIV_IDLE/DIV_CALC/DIV_FIX;
  - the WIDTH default;
  - the LOG2 counter width (6 bits for 32).
- One natural sub-module, div_step: combinational one-iteration shift/trial-subtract/select.
  - Inputs: rem, quo, divisor.
  - Outputs: the next rem and quo.
  - Lets the bench unit-test the iteration on its own.

Test Plan:
- Unsigned, basic: DIVU a=100, b=7 -> after 33 edges ready=1, div_lo=14, div_hi=2, div_by_zero=0; ready low for edges 1..32.
- Signed, all sign combinations:
  - a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - a=7, b=-2 -> lo=-3, hi=1.
  - a=-7, b=-2 -> lo=3, hi=-1.
- Boundaries:
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF, hi=0.
- Divide by zero: DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1, latency 33.
  - A following DIVU 9/3 clears the flag and gives lo=3, hi=0.
- Cancel:
  - Start 100/7, assert cancel at edge 10 -> ready=1 after edge 10, outputs still hold the prior result.
  - Start and cancel asserted together in IDLE -> no operation starts.
  - Change a/b mid-CALC -> the result is unaffected.
- Async reset: drop resetn mid-CALC between edges -> ready=1 and outputs 0 immediately, without waiting for a clock edge.
  - Also check back-to-back starts: two accepted starts 34 edges apart both complete correctly.
